// File: rtl/read_and_d_loader_pkg.sv
// Shared definitions for the read/D(i) loader: base symbol codes, FSM states
// and default sizing.
package read_and_d_loader_pkg;

  localparam logic [1:0] SYM_A = 2'b00;
  localparam logic [1:0] SYM_C = 2'b01;
  localparam logic [1:0] SYM_G = 2'b10;
  localparam logic [1:0] SYM_T = 2'b11;

  localparam int DEPTH_DEF = 10;
  localparam int AW_DEF    = 8;
  localparam int DW_DEF    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/read_and_d_loader_ram.sv
// read_d_ram: DEPTH x W storage with one synchronous write port and one
// asynchronous read port. Contents are not reset.
module read_d_ram #(
  parameter int DEPTH = 10,
  parameter int AW    = 8,
  parameter int W     = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && (waddr < DEPTH_A)) begin
      mem[waddr[IW-1:0]] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (raddr < DEPTH_A) begin
      rdata = mem[raddr[IW-1:0]];
    end
  end

endmodule

// File: rtl/read_and_d_loader.sv
// Loads (symbol, D(i)) pairs from a valid/ready stream into read_d_ram and
// serves them to the search engine. Optional macro: READ_D_MONO_CHECK_EN.
module read_and_d_loader
  import read_and_d_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          s_last,
  input  logic [1:0]    s_sym,
  input  logic [DW-1:0] s_d,
  input  logic          ce,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] d_i,
  output logic [1:0]    read_i,
  output logic [AW-1:0] len,
  output logic          loaded,
  output logic          err_overflow,
  output logic          err_mono
);

  localparam int W = DW + 2;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic          loaded_q, loaded_d;
  logic          ovf_q, ovf_d;
  logic          accept;
  logic          we;
  logic          rd_hit;
  logic [W-1:0]  rdata;

`ifdef READ_D_MONO_CHECK_EN
  logic          mono_q, mono_d;
  logic [DW-1:0] prev_d_q, prev_d_d;
`endif

  assign s_ready = (state_q == ST_LOAD);
  // A start in the same cycle as a beat wins: the beat is dropped.
  assign accept  = s_valid & s_ready & ~start;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wptr_d   = wptr_q;
    loaded_d = loaded_q;
    ovf_d    = ovf_q;
    we       = 1'b0;
`ifdef READ_D_MONO_CHECK_EN
    mono_d   = mono_q;
    prev_d_d = prev_d_q;
`endif
    if (start) begin
      state_d  = ST_LOAD;
      len_d    = '0;
      wptr_d   = '0;
      loaded_d = 1'b0;
      ovf_d    = 1'b0;
`ifdef READ_D_MONO_CHECK_EN
      mono_d   = 1'b0;
`endif
    end else if (accept) begin
      we     = 1'b1;
      wptr_d = wptr_q + 1'b1;
      len_d  = len_q + 1'b1;
`ifdef READ_D_MONO_CHECK_EN
      if ((len_q != '0) && (s_d < prev_d_q)) begin
        mono_d = 1'b1;
      end
      prev_d_d = s_d;
`endif
      if (s_last || (len_q == LAST_IDX)) begin
        state_d  = ST_DONE;
        loaded_d = 1'b1;
        if (!s_last) begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      wptr_q   <= '0;
      loaded_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      wptr_q   <= wptr_d;
      loaded_q <= loaded_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef READ_D_MONO_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mono_q <= 1'b0;
    end else begin
      mono_q <= mono_d;
    end
  end

  // Previous D is datapath state; only the flag needs reset.
  always_ff @(posedge clk) begin
    prev_d_q <= prev_d_d;
  end

  assign err_mono = mono_q;
`else
  assign err_mono = 1'b0;
`endif

  read_d_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wptr_q),
    .wdata ({s_sym, s_d}),
    .raddr (addr),
    .rdata (rdata)
  );

  // Entries at or beyond len are stale or not yet committed and read as zero.
  assign rd_hit       = ce && (addr < len_q);
  assign d_i          = rd_hit ? rdata[DW-1:0] : '0;
  assign read_i       = rd_hit ? rdata[W-1:DW] : 2'b00;
  assign len          = len_q;
  assign loaded       = loaded_q;
  assign err_overflow = ovf_q;

endmodule

// File: tb/tb_read_and_d_loader.sv
// Testbench for read_and_d_loader: directed vector table, multi-cycle corner
// sequences and randomized loads against a queue-based reference model.
module tb_read_and_d_loader;

  localparam int DEPTH = 10;
  localparam int AW    = 8;
  localparam int DW    = 8;

`ifdef READ_D_MONO_CHECK_EN
  localparam logic MONO_EN = 1'b1;
`else
  localparam logic MONO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          s_valid;
  logic          s_ready;
  logic          s_last;
  logic [1:0]    s_sym;
  logic [DW-1:0] s_d;
  logic          ce;
  logic [AW-1:0] addr;
  logic [DW-1:0] d_i;
  logic [1:0]    read_i;
  logic [AW-1:0] len;
  logic          loaded;
  logic          err_overflow;
  logic          err_mono;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  read_and_d_loader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_last       (s_last),
    .s_sym        (s_sym),
    .s_d          (s_d),
    .ce           (ce),
    .addr         (addr),
    .d_i          (d_i),
    .read_i       (read_i),
    .len          (len),
    .loaded       (loaded),
    .err_overflow (err_overflow),
    .err_mono     (err_mono)
  );

  typedef struct {
    logic [1:0]    sym;
    logic [DW-1:0] d;
    logic          last;
    int            exp_len;
    logic          exp_loaded;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [1:0] sym, input logic [DW-1:0] d, input logic last);
    s_valid = 1'b1; s_sym = sym; s_d = d; s_last = last;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic chk_rd(input string nm, input logic c, input int a,
                        input logic [1:0] esym, input logic [DW-1:0] ed);
    ce = c; addr = AW'(a);
    #1;
    chk({nm, "_sym"}, read_i, esym);
    chk({nm, "_d"}, d_i, ed);
  endtask

  // Reference model state
  logic [DW+1:0] m_q[$];
  logic          m_loading, m_loaded, m_ovf;

  function automatic logic model_mono();
    for (int i = 1; i < m_q.size(); i++)
      if (m_q[i][DW-1:0] < m_q[i-1][DW-1:0]) return MONO_EN;
    return 1'b0;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] syms [10];
    int         ds   [10];
    syms = '{2'b01, 2'b00, 2'b11, 2'b10, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
    ds   = '{0, 1, 1, 2, 3, 3, 4, 5, 6, 7};
    for (int i = 0; i < 10; i++)
      tbl[i] = '{sym: syms[i], d: DW'(ds[i]), last: (i == 9),
                 exp_len: i + 1, exp_loaded: (i == 9)};

    rst_n = 1'b0; start = 1'b1; s_valid = 1'b0; s_last = 1'b0;
    s_sym = '0; s_d = '0; ce = 1'b0; addr = '0;
    tick(); tick();
    start = 1'b0;
    chk("rst_start_ready", s_ready, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", s_ready, 0);
    chk("rst_loaded", loaded, 0);
    chk("rst_len", len, 0);
    chk("rst_ovf", err_overflow, 0);
    chk("rst_mono", err_mono, 0);
    chk_rd("rst_rd0", 1'b1, 0, 2'b00, 0);

    // Full load from the vector table
    pulse_start();
    chk("load_ready", s_ready, 1);
    for (int i = 0; i < 10; i++) begin
      beat(tbl[i].sym, tbl[i].d, tbl[i].last);
      chk($sformatf("tbl_len_%0d", i), len, tbl[i].exp_len);
      chk($sformatf("tbl_loaded_%0d", i), loaded, tbl[i].exp_loaded);
    end
    chk("tbl_ovf", err_overflow, 0);
    chk("tbl_ready_done", s_ready, 0);
    chk_rd("tbl_rd3", 1'b1, 3, 2'b10, 2);
    chk_rd("tbl_rd9", 1'b1, 9, 2'b01, 7);
    chk_rd("tbl_rd10", 1'b1, 10, 2'b00, 0);
    chk_rd("tbl_rd_ce0", 1'b0, 3, 2'b00, 0);
    beat(2'b11, 8'hEE, 1'b1);
    chk("done_ignore_len", len, 10);
    chk_rd("done_ignore_rd0", 1'b1, 0, 2'b01, 0);

    // Overflow: DEPTH beats without s_last
    pulse_start();
    chk("ovf_clr_loaded", loaded, 0);
    for (int i = 0; i < 9; i++) beat(2'b00, DW'(i), 1'b0);
    chk("ovf_pre_flag", err_overflow, 0);
    chk("ovf_pre_loaded", loaded, 0);
    beat(2'b00, 9, 1'b0);
    chk("ovf_flag", err_overflow, 1);
    chk("ovf_loaded", loaded, 1);
    chk("ovf_len", len, 10);

    // Restart mid-load with a simultaneous beat
    pulse_start();
    chk("rs_ovf_clr", err_overflow, 0);
    for (int i = 0; i < 4; i++) beat(2'b01, DW'(i + 1), 1'b0);
    chk("rs_len4", len, 4);
    start = 1'b1;
    beat(2'b11, 9, 1'b0);
    start = 1'b0;
    chk("rs_len0", len, 0);
    chk_rd("rs_rd0_empty", 1'b1, 0, 2'b00, 0);
    s_valid = 1'b1; s_sym = 2'b10; s_d = 5; s_last = 1'b0;
    chk_rd("rs_rd0_same_cycle", 1'b1, 0, 2'b00, 0);
    tick();
    s_valid = 1'b0;
    chk("rs_len1", len, 1);
    chk_rd("rs_rd0_new", 1'b1, 0, 2'b10, 5);

    // Monotonic check
    pulse_start();
    beat(2'b00, 0, 1'b0);
    beat(2'b01, 3, 1'b0);
    chk("mono_after2", err_mono, 0);
    beat(2'b10, 2, 1'b1);
    chk("mono_after3", err_mono, MONO_EN);
    chk_rd("mono_rd2", 1'b1, 2, 2'b10, 2);
    pulse_start();
    chk("mono_clr", err_mono, 0);

    // Randomized loads with gaps, mid-load reads and overflow
    for (int ld = 0; ld < 20; ld++) begin
      int target, sent, cyc;
      target = $urandom_range(1, 12);
      pulse_start();
      m_q.delete(); m_loading = 1'b1; m_loaded = 1'b0; m_ovf = 1'b0;
      sent = 0; cyc = 0;
      while (m_loading && cyc < 200) begin
        int a;
        logic v;
        v = ($urandom_range(0, 2) != 0);
        s_valid = v;
        s_sym = 2'($urandom_range(0, 3));
        s_d = DW'($urandom_range(0, 60));
        s_last = (sent == target - 1);
        a = $urandom_range(0, 11);
        ce = 1'b1; addr = AW'(a);
        #1;
        chk("rnd_ready", s_ready, m_loading);
        if (a < m_q.size()) begin
          chk("rnd_mid_sym", read_i, m_q[a][DW+1:DW]);
          chk("rnd_mid_d", d_i, m_q[a][DW-1:0]);
        end else begin
          chk("rnd_mid_sym", read_i, 0);
          chk("rnd_mid_d", d_i, 0);
        end
        tick();
        if (v) begin
          m_q.push_back({s_sym, s_d});
          sent++;
          if (s_last || m_q.size() == DEPTH) begin
            m_loading = 1'b0; m_loaded = 1'b1; m_ovf = !s_last;
          end
        end
        s_valid = 1'b0; s_last = 1'b0;
        chk("rnd_len", len, m_q.size());
        chk("rnd_loaded", loaded, m_loaded);
        cyc++;
      end
      chk("rnd_timeout", m_loading, 0);
      chk("rnd_ovf", err_overflow, m_ovf);
      chk("rnd_mono", err_mono, model_mono());
      for (int a = 0; a < 13; a++) begin
        logic c;
        c = ($urandom_range(0, 3) != 0);
        if (c && a < m_q.size())
          chk_rd("rnd_rb", c, a, m_q[a][DW+1:DW], m_q[a][DW-1:0]);
        else
          chk_rd("rnd_rb", c, a, 2'b00, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/read_and_d_loader.md
# read_and_d_loader

Writable buffer for short-read symbols and per-position search bounds D(i). The host streams (symbol, D) pairs in through a valid/ready port, and the block stores them in an internal RAM. The search engine reads them back through a `ce`/`addr` port that returns `d_i`/`read_i`, which lets one bitstream serve successive reads without re-synthesis. The block sits between the host/DMA side and the backward-search core.

## Interface
Parameters:
- `DEPTH`, 10: maximum number of entries (read length).
- `AW`, 8: address width of the write pointer and the read port.
- `DW`, 8: width of D(i).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle pulse that clears the buffer and opens a new load.
- `s_valid` in 1: input beat valid.
- `s_ready` out 1: block accepts a beat this cycle.
- `s_last` in 1: marks the final beat of the read.
- `s_sym` in 2: base symbol; 00=A, 01=C, 10=G, 11=T.
- `s_d` in DW: D(i) for this position.
- `ce` in 1: read enable.
- `addr` in AW: read index i.
- `d_i` out DW: stored D(i).
- `read_i` out 2: stored symbol.
- `len` out AW: number of valid entries.
- `loaded` out 1: load complete; buffer is stable.
- `err_overflow` out 1: DEPTH beats were taken without `s_last`.
- `err_mono` out 1: D sequence decreased (see Configuration).

## Operation
- The FSM has three states: IDLE, LOAD and DONE. Reset enters IDLE.
- **IDLE → LOAD** on `start`. The same edge clears `len`, `wptr`, `loaded`, `err_overflow` and `err_mono`.
- **LOAD**:
  - `s_ready`=1.
  - Accept = `s_valid & s_ready`.
  - Each accept writes `{s_sym, s_d}` to `mem[wptr]`, then increments `wptr` and `len`.
- **LOAD → DONE** on an accepted beat when either condition holds:
  - `s_last`=1; or
  - this is the DEPTH-th beat. If `s_last`=0 on that beat, `err_overflow` is set as well.
- **DONE**:
  - `s_ready`=0 and `loaded`=1.
  - `start` returns the block to LOAD with all clears applied.
- **`start` during LOAD**: restarts the load. A beat presented in the same cycle is discarded and not written.
- **`start` and reset together**: reset wins.
- **Read port** is combinational:
  - `ce`=0 → `d_i`=0, `read_i`=0.
  - `addr` ≥ `len` → 0, 0.
  - Otherwise → `mem[addr]`.
- Reads during LOAD are legal and return only entries already committed.
- Memory array is not reset. Stale data is masked by the `len` check.
- Widths: `len` saturates at DEPTH. DEPTH must be ≤ 2^AW − 1.

## Timing
- Reset values:
  - `s_ready`=0, `loaded`=0, `len`=0, `err_overflow`=0, `err_mono`=0.
  - `d_i`=0 and `read_i`=0 for any `addr`.
- `s_ready` is a decode of the state only. It has no combinational path from `s_valid`.
- Write-to-read latency is 1 cycle. An entry accepted at edge N is readable from after edge N.
- A read of the address being written in the same cycle returns 0, because it is still ≥ `len`.
- `loaded` rises at the edge that accepts the final beat.
- Error flags are sticky until the next `start` or reset.
- Throughput: one beat per cycle.

## Configuration
- Macro: `READ_D_MONO_CHECK_EN`.
- **Defined**: D(i) must be non-decreasing within a load.
  - An accepted beat with `s_d` < the previously accepted `s_d` sets `err_mono`.
  - The first beat of a load is exempt.
  - The offending beat is still written.
- **Undefined**: no previous-D register exists and `err_mono` is tied to 0.

## Structure
- Shared package holds:
  - symbol encodings `SYM_A`/`SYM_C`/`SYM_G`/`SYM_T`;
  - FSM state enum;
  - default `DEPTH`/`DW`.
- Storage is one sub-module, `read_d_ram`:
  - DEPTH × (2+DW) array;
  - one synchronous write port;
  - one asynchronous read port.
- FSM, pointers and error logic stay in the top module.

## Test plan
- **Reset and idle:** reset, then `ce`=1 at addr 0 → `d_i`=0, `read_i`=0, `s_ready`=0, `loaded`=0.
- **Full load and readback:** `start`, then 10 back-to-back beats (C,0)(A,1)(T,1)(G,2)…, last with `s_last` → `len`=10 and `loaded`=1 on the 10th edge. Readback of addr 3 gives `read_i`=10, `d_i`=2. addr 10 → 0.
- **Backpressure and gaps:** deassert `s_valid` randomly mid-load → no duplicate or missing entries, `len` matches the beat count. After DONE, `s_valid`=1 is ignored.
- **Overflow:** 10 beats without `s_last` → `err_overflow`=1, `loaded`=1, `len`=10.
- **Restart:** `start` mid-load after 4 beats, with a beat in the same cycle → `len`=0 and the beat is dropped. Reading addr 0 returns 0 until the new beat lands.
- **Monotonic check:** with `READ_D_MONO_CHECK_EN`, D sequence 0,3,2 → `err_mono`=1 after the third accept and `d_i`@2 = 2. Without the macro, `err_mono` stays 0.
